inst_sram_axi_bridge: RTL and testbench

- Read-only bridge between the fetch stage's SRAM-like instruction port (req/addr_ok/data_ok) and an AXI4 read master (AR/R channels).
- Sits directly upstream of the fetch stage and is the sole source of inst_sram_addr_ok, inst_sram_data_ok and inst_sram_rdata.
- Single beat per request, in-order return, up to MAX_OUTSTANDING reads in flight.

---
 rtl/inst_sram_axi_bridge.sv | 135 +++++++++++++
 tb/tb_inst_sram_axi_bridge.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_sram_axi_bridge.sv
// Read-only bridge from the fetch stage's SRAM-like instruction port to an
// AXI4 read master. It issues one single-beat AR per accepted request and
// passes R beats back in order, with up to MAX_OUTSTANDING reads in flight.
//
// Handshake semantics: on AR a transfer happens in a cycle where
// arvalid & arready are both high, and araddr/arsize stay stable while
// arvalid is high. On R a beat is consumed in a cycle where rvalid & rready
// are both high. On the fetch side a request is taken only in a cycle where
// inst_sram_addr_ok is high, and data is delivered only in a cycle where
// inst_sram_data_ok is high.
module inst_sram_axi_bridge #(
  parameter logic [3:0]  AXI_ID          = 4'd0,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          PROTOCOL_CHECKS = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_t;

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

  ar_state_t  state;
  logic [1:0] cnt;

  // Ordering is guaranteed by the slave returning in order, so these
  // inputs carry nothing the bridge needs.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast};

  // Fixed AR attributes: single incrementing beat, normal access.
  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  // Accept only when no AR is pending and there is room for another read.
  assign inst_sram_addr_ok = ~reset & inst_sram_req & ~inst_sram_wr &
                             (state == AR_IDLE) & (cnt < MAX_CNT);

  // R beats are only consumed while a read is outstanding; data is passed
  // straight through with no added latency.
  assign rready            = (cnt != 2'd0);
  assign inst_sram_data_ok = rvalid & rready;
  assign inst_sram_rdata   = rdata;

  // AR channel FSM: latch the request on accept, hold it until arready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= AR_IDLE;
      arvalid <= 1'b0;
      araddr  <= 32'd0;
      arsize  <= 3'd0;
    end else begin
      case (state)
        AR_IDLE: begin
          if (inst_sram_addr_ok) begin
            state   <= AR_SEND;
            arvalid <= 1'b1;
            araddr  <= inst_sram_addr;
            arsize  <= {1'b0, inst_sram_size};
          end
        end
        AR_SEND: begin
          if (arready) begin
            state   <= AR_IDLE;
            arvalid <= 1'b0;
          end
        end
        default: begin
          state   <= AR_IDLE;
          arvalid <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding-read counter: up on accept, down on returned beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 2'd0;
    end else begin
      case ({inst_sram_addr_ok, inst_sram_data_ok})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Protocol violations from the fetch side or the slave.
  no_write_req: assert property (@(posedge clk) disable iff (reset || !PROTOCOL_CHECKS)
    !(inst_sram_req && inst_sram_wr))
    else $error("write request on read-only instruction port");

  no_stray_beat: assert property (@(posedge clk) disable iff (reset || !PROTOCOL_CHECKS)
    !(rvalid && (cnt == 2'd0)))
    else $error("R beat with no outstanding read");

  cnt_in_range: assert property (@(posedge clk) disable iff (reset)
    cnt <= MAX_CNT)
    else $error("outstanding count above limit");

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Bench for inst_sram_axi_bridge: directed steps then random traffic, all
// checked against a transaction-level model (pending-AR flag plus a queue of
// accepted addresses awaiting their R beat).
module tb_inst_sram_axi_bridge;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  // Protocol checks are off so illegal-write and stray-beat behaviour can be
  // exercised; the bench checks the resulting outputs itself.
  inst_sram_axi_bridge #(
    .AXI_ID(4'd0),
    .MAX_OUTSTANDING(MAX),
    .PROTOCOL_CHECKS(1'b0)
  ) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];        // accepted addresses awaiting their R beat
  logic        ar_pending = 1'b0;
  logic [31:0] last_addr  = 32'd0;
  logic [1:0]  last_size  = 2'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
  task automatic cycle(input logic rst, input logic req, input logic wr,
                       input logic [1:0] size, input logic [31:0] addr,
                       input logic ar_rdy, input logic r_vld,
                       input logic [31:0] r_data, input logic [1:0] r_resp);
    logic exp_addr_ok, exp_rready, exp_data_ok;
    reset          = rst;
    inst_sram_req  = req;
    inst_sram_wr   = wr;
    inst_sram_size = size;
    inst_sram_addr = addr;
    inst_sram_wstrb = 4'($urandom);
    inst_sram_wdata = $urandom;
    arready        = ar_rdy;
    rvalid         = r_vld;
    rdata          = r_data;
    rresp          = r_resp;
    rid            = 4'd0;
    rlast          = r_vld;
    @(negedge clk);
    exp_addr_ok = !rst && req && !wr && !ar_pending && (exp_q.size() < MAX);
    exp_rready  = (exp_q.size() != 0);
    exp_data_ok = r_vld && exp_rready;
    check("addr_ok", 32'(inst_sram_addr_ok), 32'(exp_addr_ok));
    check("data_ok", 32'(inst_sram_data_ok), 32'(exp_data_ok));
    check("rready",  32'(rready),  32'(exp_rready));
    check("arvalid", 32'(arvalid), 32'(ar_pending));
    check("araddr",  araddr, last_addr);
    check("arsize",  32'(arsize), {29'd0, 1'b0, last_size});
    check("cnt",     32'(dut.cnt), 32'(exp_q.size()));
    if (exp_data_ok) check("rdata", inst_sram_rdata, r_data);
    check("ar_const", {arid, arlen, arburst, arlock, arcache, arprot, 8'd0},
          {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 8'd0});
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      ar_pending = 1'b0;
      last_addr  = 32'd0;
      last_size  = 2'd0;
    end else begin
      if (ar_pending && ar_rdy) ar_pending = 1'b0;
      if (exp_data_ok) void'(exp_q.pop_front());
      if (exp_addr_ok) begin
        ar_pending = 1'b1;
        last_addr  = addr;
        last_size  = size;
        exp_q.push_back(addr);
      end
    end
  endtask

  task automatic idle(input logic ar_rdy);
    cycle(1'b0, 1'b0, 1'b0, 2'd2, 32'd0, ar_rdy, 1'b0, 32'd0, 2'd0);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic ar_rdy);
    cycle(1'b0, 1'b1, 1'b0, 2'd2, addr, ar_rdy, 1'b0, 32'd0, 2'd0);
  endtask

  task automatic beat(input logic [31:0] data, input logic [1:0] resp);
    cycle(1'b0, 1'b0, 1'b0, 2'd2, 32'd0, 1'b0, 1'b1, data, resp);
  endtask

  initial begin
    logic [31:0] a;
    logic        rv, rq, rs;
    // Initial reset: outputs are unknown until the first edge, so no checks.
    reset = 1'b1; inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd0;
    inst_sram_addr = 32'd0; inst_sram_wstrb = 4'd0; inst_sram_wdata = 32'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0; rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    idle(1'b0);

    // Single fetch
    fetch(32'h1C00_0000, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    beat(32'h0280_0000, 2'd0);
    idle(1'b0);

    // AR backpressure, then in-order return with an error response
    fetch(32'h1C00_0010, 1'b0);
    repeat (5) fetch(32'h1C00_0014, 1'b0);
    fetch(32'h1C00_0014, 1'b1);
    fetch(32'h1C00_0014, 1'b0);
    idle(1'b1);
    beat(32'hAAAA_0000, 2'b00);
    beat(32'hBBBB_0000, 2'b10);
    idle(1'b0);

    // Outstanding limit
    fetch(32'h1C00_0000, 1'b1);
    fetch(32'h1C00_0004, 1'b1);
    repeat (3) fetch(32'h1C00_0008, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 2'd2, 32'h1C00_0008, 1'b1, 1'b1, 32'h1111_0000, 2'd0);
    idle(1'b1);
    beat(32'h2222_0000, 2'd0);
    beat(32'h3333_0000, 2'd0);
    idle(1'b0);

    // Stray R beat
    beat(32'hDEAD_BEEF, 2'd0);

    // Illegal write
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 2'd2, 32'h1C00_0020, 1'b1, 1'b0, 32'd0, 2'd0);

    // Reset after accept, before the R beat
    fetch(32'h1C00_0040, 1'b0);
    idle(1'b1);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 32'd0, 2'd0);
    fetch(32'h1C00_0000, 1'b0);
    idle(1'b1);
    beat(32'h0280_0000, 2'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      a  = {$urandom_range(0, 32'hFFFF), 16'd0} | (32'($urandom_range(0, 255)) << 2);
      rq = ($urandom_range(0, 9) < 7);
      rv = (exp_q.size() != 0) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 99) == 0);
      cycle(rs, rq, ($urandom_range(0, 29) == 0), 2'($urandom_range(0, 2)), a,
            1'($urandom_range(0, 1)), rv, $urandom, 2'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
